// File: rtl/program_loader_pkg.sv
// program_loader_pkg: state encoding, widths and parameter defaults shared by the loader and its hold timer.
package program_loader_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int unsigned DATA_HOLD_DEF = 2;
  localparam int unsigned CPU_RST_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_POST,
    S_RELEASE,
    S_CRST,
    S_DONE
  } state_e;

  // Timer load value for a wait of n cycles, since the timer counts down to and including zero.
  function automatic logic [3:0] ticks(input int unsigned n);
    return (n == 0) ? 4'd0 : 4'(n - 1);
  endfunction

endpackage

// File: rtl/program_loader_hold_timer.sv
// program_loader_hold_timer: 4-bit load/decrement counter with a zero flag.
module program_loader_hold_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;

  assign zero_o = cnt_q == 4'd0;

endmodule

// File: rtl/program_loader.sv
// program_loader: streams host bytes into CPU RAM through the halt-mode programming port, then resets the CPU.
// Defining LOADER_CHECKSUM_EN adds checksum_o, the mod-256 sum of bytes accepted since the last start.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned DATA_HOLD      = DATA_HOLD_DEF,
  parameter int unsigned CPU_RST_CYCLES = CPU_RST_CYCLES_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [8:0]        len_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              halt_o,
  output logic              new_in_o,
  output logic [ADDR_W-1:0] program_addr_o,
  output logic [DATA_W-1:0] program_data_o,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum_o
`endif
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [8:0]          len_q, len_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   byte_q, byte_d;
  logic                tmr_load, tmr_dec, tmr_zero;
  logic [3:0]          tmr_val;
  logic                launch, take;
  logic                halt_d, new_in_d, in_ready_d, cpu_rst_d, busy_d, done_d;
  logic [ADDR_W-1:0]   program_addr_d;
  logic [DATA_W-1:0]   program_data_d;

  assign launch = state_q == S_IDLE && start_i;
  assign take   = state_q == S_WAIT && in_valid_i && in_ready_o;

  program_loader_hold_timer u_hold (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    tmr_load = 1'b0;
    tmr_val  = 4'd0;
    tmr_dec  = 1'b0;
    case (state_q)
      S_IDLE: if (launch) begin
        cur_d   = base_addr_i;
        len_d   = len_i;
        cnt_d   = 9'd0;
        state_d = (len_i == 9'd0) ? S_DONE : S_WAIT;
      end
      S_WAIT: if (take) begin
        byte_d   = in_data_i;
        tmr_load = 1'b1;
        tmr_val  = ticks(DATA_HOLD);
        state_d  = S_DATA;
      end
      S_DATA: begin
        tmr_dec = 1'b1;
        state_d = tmr_zero ? S_POST : S_DATA;
      end
      S_POST: begin
        cur_d   = cur_q + 8'd1;
        cnt_d   = cnt_q + 9'd1;
        state_d = (cnt_q + 9'd1 == len_q) ? S_RELEASE : S_WAIT;
      end
      // RELEASE already counts as the first cpu_rst cycle.
      S_RELEASE: begin
        tmr_load = CPU_RST_CYCLES > 1;
        tmr_val  = ticks(CPU_RST_CYCLES - 1);
        state_d  = (CPU_RST_CYCLES > 1) ? S_CRST : S_DONE;
      end
      S_CRST: begin
        tmr_dec = 1'b1;
        state_d = tmr_zero ? S_DONE : S_CRST;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  assign halt_d         = state_d inside {S_WAIT, S_DATA, S_POST};
  assign new_in_d       = state_d inside {S_WAIT, S_POST};
  assign in_ready_d     = state_d == S_WAIT;
  assign cpu_rst_d      = state_d inside {S_RELEASE, S_CRST};
  assign busy_d         = state_d != S_IDLE;
  assign done_d         = state_d == S_DONE;
  assign program_addr_d = new_in_d ? cur_d : '0;
  assign program_data_d = (state_d == S_DATA) ? byte_d : '0;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      cur_q          <= '0;
      len_q          <= '0;
      cnt_q          <= '0;
      byte_q         <= '0;
      halt_o         <= 1'b0;
      new_in_o       <= 1'b0;
      in_ready_o     <= 1'b0;
      cpu_rst_o      <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      program_addr_o <= '0;
      program_data_o <= '0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      byte_q         <= byte_d;
      halt_o         <= halt_d;
      new_in_o       <= new_in_d;
      in_ready_o     <= in_ready_d;
      cpu_rst_o      <= cpu_rst_d;
      busy_o         <= busy_d;
      done_o         <= done_d;
      program_addr_o <= program_addr_d;
      program_data_o <= program_data_d;
    end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sum_q <= '0;
    else sum_q <= launch ? '0 : take ? sum_q + in_data_i : sum_q;

  assign checksum_o = sum_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: random-stimulus bench with a CPU RAM model behind the programming port.
module tb_program_loader;

  localparam int DH = 2;
  localparam int CR = 4;
  localparam int TO = 400;

  logic       clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, in_valid_i = 1'b0;
  logic [7:0] base_addr_i = '0, in_data_i = '0;
  logic [8:0] len_i = '0;
  logic       in_ready_o, halt_o, new_in_o, cpu_rst_o, busy_o, done_o;
  logic [7:0] program_addr_o, program_data_o;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum_o;
`endif

  int n_tests = 0, n_fail = 0;
  logic [7:0] ram [256];
  logic [7:0] bytes_q [256];
  logic [7:0] mar = '0;
  int halt_cycles, rst_cycles, done_cnt, viol, bad_run, run, timeouts;

  always #5 clk_i = ~clk_i;

  program_loader #(.DATA_HOLD(DH), .CPU_RST_CYCLES(CR)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .len_i          (len_i),
    .in_data_i      (in_data_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .halt_o         (halt_o),
    .new_in_o       (new_in_o),
    .program_addr_o (program_addr_o),
    .program_data_o (program_data_o),
    .cpu_rst_o      (cpu_rst_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum_o     (checksum_o)
`endif
  );

  // CPU side: address phase latches MAR, every halted data-phase cycle writes RAM[MAR].
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mar = '0;
      run = 0;
    end else begin
      if (halt_o && new_in_o) mar = program_addr_o;
      if (halt_o && !new_in_o) begin
        ram[mar] = program_data_o;
        run++;
        if (program_addr_o != 0 || in_ready_o) viol++;
      end else begin
        if (run != 0 && run != DH) bad_run++;
        run = 0;
        if (program_data_o != 0) viol++;
      end
      if (!halt_o && (new_in_o || program_addr_o != 0 || in_ready_o)) viol++;
      if (halt_o && cpu_rst_o) viol++;
      if (halt_o) halt_cycles++;
      if (cpu_rst_o) rst_cycles++;
      if (done_o) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    halt_cycles = 0;
    rst_cycles  = 0;
    done_cnt    = 0;
    viol        = 0;
    bad_run     = 0;
    timeouts    = 0;
    for (int a = 0; a < 256; a++) ram[a] = 8'(a) ^ 8'hC3;
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) bytes_q[i] = 8'($urandom);
  endtask

  task automatic run_load(input logic [7:0] base, input int n, input bit stall,
                          input bit mid_start, input bit abort);
    int t;
    @(posedge clk_i); #1;
    start_i = 1'b1; base_addr_i = base; len_i = 9'(n);
    @(posedge clk_i); #1;
    start_i = 1'b0; base_addr_i = 8'($urandom); len_i = 9'($urandom_range(1, 256));
    if (n == 0) check("len0_done_next", {31'd0, done_o}, 1);
    for (int i = 0; i < n; i++) begin
      if (stall) repeat ($urandom_range(0, 4)) begin @(posedge clk_i); #1; end
      in_valid_i = 1'b1;
      in_data_i  = bytes_q[i];
      if (mid_start && i == 1) begin
        start_i = 1'b1; len_i = 9'd1; base_addr_i = 8'h80;
      end
      t = 0;
      while (!in_ready_o && t < TO) begin @(posedge clk_i); #1; t++; end
      if (t >= TO) begin
        timeouts++;
        in_valid_i = 1'b0; start_i = 1'b0;
        return;
      end
      @(posedge clk_i); #1;
      in_valid_i = 1'b0; in_data_i = 8'($urandom); start_i = 1'b0;
      if (abort && i == 1) begin
        #2 rst_ni = 1'b0;
        #1 check("abort_outs_async", {26'd0, halt_o, new_in_o, cpu_rst_o, busy_o, done_o, in_ready_o}, 0);
        return;
      end
    end
    t = 0;
    while (done_cnt == 0 && t < TO) begin @(posedge clk_i); #1; t++; end
    if (t >= TO) timeouts++;
    @(posedge clk_i); #1;
    check("idle_after_done", {29'd0, busy_o, halt_o, cpu_rst_o}, 0);
  endtask

  task automatic verify_load(input logic [7:0] base, input int n, input bit b2b);
    logic [7:0] exp [256];
    int bad = 0, s = 0;
    for (int a = 0; a < 256; a++) exp[a] = 8'(a) ^ 8'hC3;
    for (int i = 0; i < n; i++) begin
      exp[8'(int'(base) + i)] = bytes_q[i];
      s += int'(bytes_q[i]);
    end
    for (int a = 0; a < 256; a++) if (ram[a] !== exp[a]) bad++;
    check("ram_mismatches", bad, 0);
    check("done_pulses", done_cnt, 1);
    check("cpu_rst_cycles", rst_cycles, (n == 0) ? 0 : CR);
    if (b2b) check("halt_cycles", halt_cycles, n * (DH + 2));
    else check("halt_min", {31'd0, halt_cycles >= n * (DH + 2)}, 1);
    check("phase_violations", viol, 0);
    check("data_hold_runs", bad_run, 0);
    check("timeouts", timeouts, 0);
`ifdef LOADER_CHECKSUM_EN
    check("checksum", {24'd0, checksum_o}, 32'(8'(s)));
`endif
  endtask

  initial begin
    int n;
    logic [7:0] b;
    repeat (3) @(posedge clk_i);
    #1 check("reset_outs",
             {2'd0, halt_o, new_in_o, in_ready_o, cpu_rst_o, busy_o, done_o, program_addr_o, program_data_o}, 0);
    rst_ni = 1'b1;

    clear_mon();
    bytes_q[0] = 8'h11; bytes_q[1] = 8'h22; bytes_q[2] = 8'h33;
    run_load(8'h00, 3, 1'b0, 1'b0, 1'b0);
    verify_load(8'h00, 3, 1'b1);

    clear_mon();
    for (int i = 0; i < 4; i++) bytes_q[i] = 8'hA0 + 8'(i);
    run_load(8'hFE, 4, 1'b0, 1'b0, 1'b0);
    verify_load(8'hFE, 4, 1'b1);
    check("wrap_ram00", {24'd0, ram[0]}, 32'hA2);

    clear_mon();
    bytes_q[0] = 8'hFF; bytes_q[1] = 8'h02; bytes_q[2] = 8'h10;
    run_load(8'h40, 3, 1'b0, 1'b0, 1'b0);
    verify_load(8'h40, 3, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    check("checksum_fixed", {24'd0, checksum_o}, 32'h11);
`endif

    clear_mon();
    run_load(8'h33, 0, 1'b0, 1'b0, 1'b0);
    verify_load(8'h33, 0, 1'b1);

    clear_mon();
    fill_rand(5);
    run_load(8'h20, 5, 1'b0, 1'b1, 1'b0);
    verify_load(8'h20, 5, 1'b1);

    clear_mon();
    fill_rand(16);
    b = 8'($urandom);
    run_load(b, 16, 1'b1, 1'b0, 1'b0);
    verify_load(b, 16, 1'b0);

    clear_mon();
    fill_rand(4);
    run_load(8'h10, 4, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk_i);
    #1 check("abort_no_done", done_cnt, 0);
    check("abort_held", {29'd0, halt_o, busy_o, cpu_rst_o}, 0);
    rst_ni = 1'b1;
    clear_mon();
    fill_rand(4);
    run_load(8'h10, 4, 1'b0, 1'b0, 1'b0);
    verify_load(8'h10, 4, 1'b1);

    for (int k = 0; k < 5; k++) begin
      clear_mon();
      n = $urandom_range(1, 40);
      fill_rand(n);
      b = 8'($urandom);
      run_load(b, n, 1'b1, 1'b0, 1'b0);
      verify_load(b, n, 1'b0);
    end

    clear_mon();
    fill_rand(256);
    run_load(8'h9C, 256, 1'b0, 1'b0, 1'b0);
    verify_load(8'h9C, 256, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Host-side initiator for the CPU's halt-mode RAM programming port. Drives halt, new_in, program_addr and program_data.
- Accepts a byte stream over a valid/ready handshake from a host source (UART receiver, switch bank, testbench).
- For each byte: addresses the RAM via the MAR phase, then writes via the data phase.
- When the stream completes, releases halt and holds the CPU in reset for a fixed window so execution restarts from address 0.

Parameters:
- DATA_HOLD, 2: cycles the data phase (new_in=0) is held per byte; legal range 1..15.
- CPU_RST_CYCLES, 4: cycles cpu_rst stays asserted after halt is released; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  sampled in IDLE only; begins a load. Ignored while busy.
- base_addr  in  8  first RAM address; captured on start.
- len  in  9  byte count, 0..256; captured on start.
- in_data  in  8  byte from host.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- halt  out  1  to CPU halt.
- new_in  out  1  to CPU new_in; 1 = address phase, 0 = data phase (RAM write while halt=1).
- program_addr  out  8  to CPU program_addr.
- program_data  out  8  to CPU program_data.
- cpu_rst  out  1  CPU reset request, active-high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at load completion.

Behaviour:
- Reset values: all outputs 0; state IDLE; address and count registers 0.
- Register timing: all outputs are registered. A transition sampled at edge N is visible after edge N.
- Safety invariant: whenever halt=1, new_in=0 only in DATA. This is required because halt & ~new_in writes the RAM on every such cycle.
- Gating: program_addr is 0 unless halt=1 and new_in=1. program_data is 0 outside DATA. Both feed OR-ed buses, so they must be zero when unused.
- IDLE:
  - halt=0, new_in=0.
  - On start: capture base_addr into cur and len; clear cnt.
  - If len=0: go to DONE, with halt never asserted. Otherwise go to WAIT.
- WAIT:
  - halt=1, new_in=1, program_addr=cur, in_ready=1.
  - On in_valid & in_ready: latch in_data; go to DATA.
- DATA:
  - halt=1, new_in=0, program_data=byte, program_addr=0, in_ready=0.
  - Held exactly DATA_HOLD cycles, then go to POST.
- POST:
  - One cycle: halt=1, new_in=1, program_addr=cur, program_data=0.
  - On exit: cur <= cur+1, wrapping modulo 256 (0xFF -> 0x00); cnt <= cnt+1.
  - If cnt+1 == len: go to RELEASE. Otherwise go to WAIT.
- RELEASE: one cycle with halt=0, new_in=0, cpu_rst=1; then go to CRST.
- CRST:
  - cpu_rst=1 for a further CPU_RST_CYCLES-1 cycles, giving CPU_RST_CYCLES total.
  - Then go to DONE.
- DONE: done=1 for one cycle; cpu_rst=0; then go to IDLE.
- Per-byte throughput: DATA_HOLD+2 cycles minimum. The host may stall indefinitely in WAIT with halt held.
- len=256 with base_addr≠0 wraps and overwrites nothing twice, since exactly 256 distinct addresses are written.
- in_valid outside WAIT has no effect; in_data is not sampled there.
- Reset mid-load: all outputs return to 0 immediately (asynchronous). RAM keeps its partially written contents. done is not pulsed.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- With the macro defined:
  - Extra output checksum (8 bits): the mod-256 sum of all bytes accepted since the last start.
  - Cleared on start; updated on each WAIT handshake.
  - Valid and stable from the done pulse until the next start.
- Without the macro: the checksum port and its adder are absent.

Decomposition:
- Shared header cpu_pkg.vh holds:
  - State encodings: IDLE, WAIT, DATA, POST, RELEASE, CRST, DONE.
  - Address width 8.
  - Default DATA_HOLD and CPU_RST_CYCLES.
- One natural sub-module, loader_hold_timer: a 4-bit load/decrement counter with a zero flag. It is shared by DATA and CRST.

Test Plan:
- Basic load: base_addr=0x00, len=3, bytes 0x11, 0x22, 0x33 presented back-to-back -> RAM[0..2]=0x11, 0x22, 0x33; halt high for 3*(DATA_HOLD+2) cycles; cpu_rst high 4 cycles; done pulses once.
- Phase invariant: random in_valid stalls, len=16 -> new_in=0 only in DATA; program_data=0 whenever new_in=1 or halt=0; no write to unintended addresses.
- Wrap: base_addr=0xFE, len=4, bytes 0xA0..0xA3 -> RAM[0xFE]=0xA0, RAM[0xFF]=0xA1, RAM[0x00]=0xA2, RAM[0x01]=0xA3.
- len=0 and start while busy: len=0 -> done one cycle after the IDLE exit, halt never 1. A start pulse mid-load -> ignored; byte count unchanged.
- Reset mid-load: rst=0 during the second DATA phase of len=4 -> halt, new_in, cpu_rst, busy drop to 0 asynchronously; no done. A restart loads correctly.
- LOADER_CHECKSUM_EN: bytes 0xFF, 0x02, 0x10 -> checksum=0x11 at done.
